load_store_unit: RTL and testbench

- Execute/memory stage block directly downstream of the registered ALU result.
- Takes the effective address (ALU ADD result) plus store data and funct3.
- Runs a request/grant/response transaction on the data-memory port, then returns a byte-lane-aligned, sign/zero-extended load value or store completion to writeback.
- Multi-cycle; back-pressures the pipeline through ready_o.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state type and small decode helpers used by the top and lane logic.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Width code is one the memory port can carry for this direction.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

  // Access straddles its natural alignment boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte offset after silently aligning halfwords and words down.
  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: return offset;
      F3_H, F3_HU: return {offset[1], 1'b0};
      default:     return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit. The master side (the LSU) drives
// the request fields; the slave side (memory) returns grant and read data.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: byte enables and lane-replicated store data for an access,
// and right-shift plus sign/zero extension of a returned word. Purely
// combinational so a future cache can reuse it unchanged.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] wdata_raw,
  input  logic [XLEN-1:0] rdata_raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_raw >> {offset, 3'b000};

  // Lane selection and extension by access width; funct3[2] marks unsigned loads.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be        = 4'b0000;
    wdata     = wdata_raw;
    rdata_ext = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << offset;
        wdata     = {4{wdata_raw[7:0]}};
        rdata_ext = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{wdata_raw[15:0]}};
        rdata_ext = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
      end
      F3_W: begin
        be        = 4'b1111;
        rdata_ext = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures an effective address from the ALU, runs a
// request/grant/response transaction on the data-memory port and returns an
// extended load value or store completion with a one-cycle done_o pulse.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete
// with err_o instead of being silently aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  input  logic                     req_we_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [XLEN-1:0]          req_addr_i,
  input  logic [XLEN-1:0]          req_wdata_i,
  output logic                     ready_o,
  load_store_unit_if.master        mem,
  output logic                     done_o,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     err_o
);

  localparam int unsigned    CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  lsu_state_t      state_q, state_d;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            we_q;
  logic [CW-1:0]   wdog_q, wdog_d;

  logic            capture, req_ok, misalign_trap;
  logic            timeout_hit, load_done, to_timeout;
  logic [2:0]      align_f3;
  logic [1:0]      align_off;
  logic [3:0]      align_be;
  logic [XLEN-1:0] align_wdata, align_rdata;

  logic            ready_d, mem_req_d, mem_we_d, done_d, err_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d, rdata_d;
  logic [3:0]      mem_be_d;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = is_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign misalign_trap = 1'b0;
`endif

  assign capture = (state_q == IDLE) && req_valid_i;
  assign req_ok  = is_legal(req_we_i, req_funct3_i) && !misalign_trap;

  // Lane logic sees the incoming request while accepting, the captured one afterwards.
  assign align_f3  = capture ? req_funct3_i : f3_q;
  assign align_off = capture ? align_offset(req_funct3_i, req_addr_i[1:0]) : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (align_f3),
    .offset    (align_off),
    .wdata_raw (req_wdata_i),
    .rdata_raw (mem.mem_rdata_i),
    .be        (align_be),
    .wdata     (align_wdata),
    .rdata_ext (align_rdata)
  );

  // Grant and read data win over an expiring watchdog in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign load_done   = !we_q && mem.mem_rvalid_i &&
                       (((state_q == REQ) && mem.mem_gnt_i) || (state_q == WAIT));
  assign to_timeout  = timeout_hit &&
                       (((state_q == REQ) && !mem.mem_gnt_i) ||
                        ((state_q == WAIT) && !mem.mem_rvalid_i));

  // Watchdog counts dwell time in REQ/WAIT and restarts on any state change.
  assign wdog_d = (state_d != state_q) ? '0 :
                  ((state_q == REQ) || (state_q == WAIT)) ? wdog_q + CW'(1) : '0;

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = req_ok ? REQ : RESP;
      REQ: begin
        if (mem.mem_gnt_i)   state_d = (we_q || mem.mem_rvalid_i) ? RESP : WAIT;
        else if (timeout_hit) state_d = RESP;
      end
      WAIT: if (mem.mem_rvalid_i || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ready_d     = (state_d == IDLE);
    mem_req_d   = (state_d == REQ);
    mem_we_d    = (state_d == REQ) && (capture ? req_we_i : we_q);
    mem_addr_d  = mem.mem_addr_o;
    mem_be_d    = mem.mem_be_o;
    mem_wdata_d = mem.mem_wdata_o;
    if (capture) begin
      mem_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
      mem_be_d    = align_be;
      mem_wdata_d = align_wdata;
    end
    done_d  = (state_d == RESP);
    err_d   = (capture && !req_ok) || to_timeout;
    rdata_d = load_done ? align_rdata : '0;
  end

  // State, capture, watchdog and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= IDLE;
      f3_q            <= 3'b000;
      off_q           <= 2'b00;
      we_q            <= 1'b0;
      wdog_q          <= '0;
      ready_o         <= 1'b1;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= 4'b0000;
      mem.mem_wdata_o <= '0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      rdata_o         <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      if (capture) begin
        f3_q  <= req_funct3_i;
        off_q <= align_offset(req_funct3_i, req_addr_i[1:0]);
        we_q  <= req_we_i;
      end
      ready_o         <= ready_d;
      mem.mem_req_o   <= mem_req_d;
      mem.mem_we_o    <= mem_we_d;
      mem.mem_addr_o  <= mem_addr_d;
      mem.mem_be_o    <= mem_be_d;
      mem.mem_wdata_o <= mem_wdata_d;
      done_o          <= done_d;
      err_o           <= err_d;
      rdata_o         <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the test plan
// plus randomized transactions; expectations come from a behavioural model
// and are consumed by a monitor that watches the memory port and done_o.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;

  load_store_unit_if #(.XLEN(32)) mem_if ();

  load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .ready_o      (ready_o),
    .mem          (mem_if),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          done_cyc;
  } resp_t;

  typedef struct {
    bit          no_mem;
    mreq_t       mr;
    logic [31:0] ldval;
  } model_t;

  mreq_t mreq_q[$];
  resp_t resp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour written from the access rules with plain arithmetic.
  function automatic model_t lsu_model(input bit we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [31:0] rdata);
    model_t m;
    int size, off;
    logic [31:0] sh;
    size = int'(f3[1:0]);
    m.no_mem = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                 (!we && ((f3 == 3'd4) || (f3 == 3'd5))));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00)) m.no_mem = 1'b1;
`endif
    if (size == 0)      off = int'(addr[1:0]);
    else if (size == 1) off = addr[1] ? 2 : 0;
    else                off = 0;
    m.mr.addr = addr & 32'hFFFF_FFFC;
    m.mr.we   = we;
    if (size == 0) begin
      m.mr.be    = 4'(1 << off);
      m.mr.wdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
    end else if (size == 1) begin
      m.mr.be    = 4'(3 << off);
      m.mr.wdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
    end else begin
      m.mr.be    = 4'hF;
      m.mr.wdata = wdata;
    end
    sh = rdata >> (8 * off);
    case (f3)
      3'd0:    m.ldval = (sh & 32'hFF) - (sh[7] ? 32'h100 : 32'h0);
      3'd1:    m.ldval = (sh & 32'hFFFF) - (sh[15] ? 32'h1_0000 : 32'h0);
      3'd4:    m.ldval = sh & 32'hFF;
      3'd5:    m.ldval = sh & 32'hFFFF;
      default: m.ldval = sh;
    endcase
    if (m.no_mem || we) m.ldval = 32'h0;
    return m;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) check(name, 32'(ready_o), 32'd1);
  endtask

  // One transaction, acting as both requester and memory.
  // rdly < 0: read data never returns. abort: reset is pulsed while in WAIT.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int gdly, input int rdly, input bit abort);
    model_t m;
    resp_t  r;
    int     t;
    m = lsu_model(we, f3, addr, wdata, rdata);
    wait_ready("ready_before_issue");
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    t = cyc;
    r.err       = m.no_mem || (!we && rdly < 0);
    r.rdata     = r.err ? 32'h0 : m.ldval;
    r.chk_rdata = r.err || !we;
    if (m.no_mem)        r.done_cyc = t + 1;
    else if (we)         r.done_cyc = t + 2 + gdly;
    else if (rdly < 0)   r.done_cyc = t + 2 + gdly + TO;
    else if (rdly == 0)  r.done_cyc = t + 2 + gdly;
    else                 r.done_cyc = t + 2 + gdly + rdly;
    if (!abort) resp_q.push_back(r);
    if (!m.no_mem) mreq_q.push_back(m.mr);
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    req_funct3_i = 3'($urandom_range(0, 7));
    check("ready_low_after_accept", 32'(ready_o), 32'd0);
    if (!m.no_mem) begin
      repeat (gdly) begin @(posedge clk); #1; end
      mem_if.mem_gnt_i = 1'b1;
      if (!we && rdly == 0) begin
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = rdata;
      end
      @(posedge clk); #1;
      mem_if.mem_gnt_i    = 1'b0;
      mem_if.mem_rvalid_i = 1'b0;
      mem_if.mem_rdata_i  = $urandom;
      if (abort) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ready",    32'(ready_o),            32'd1);
        check("rst_mem_req",  32'(mem_if.mem_req_o),   32'd0);
        check("rst_mem_we",   32'(mem_if.mem_we_o),    32'd0);
        check("rst_done",     32'(done_o),             32'd0);
        check("rst_err",      32'(err_o),              32'd0);
        check("rst_addr",     mem_if.mem_addr_o,       32'd0);
        check("rst_be",       32'(mem_if.mem_be_o),    32'd0);
        check("rst_wdata",    mem_if.mem_wdata_o,      32'd0);
        check("rst_rdata",    rdata_o,                 32'd0);
        // Late read data for the abandoned load must be ignored.
        mem_if.mem_rvalid_i = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_rvalid_i = 1'b0;
        return;
      end
      if (!we && rdly > 0) begin
        repeat (rdly - 1) begin @(posedge clk); #1; end
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = rdata;
        @(posedge clk); #1;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = $urandom;
      end
    end
    wait_ready("done_wait");
  endtask

  // Monitor: memory request fields while mem_req_o is up, responses on done_o.
  always @(negedge clk) begin
    mreq_t e;
    resp_t r;
    if (mem_if.mem_req_o === 1'b1) begin
      if (mreq_q.size() == 0) begin
        check("mem_req_spurious", 32'(mem_if.mem_req_o), 32'd0);
      end else begin
        e = mreq_q[0];
        check("mem_addr", mem_if.mem_addr_o, e.addr);
        check("mem_be",   32'(mem_if.mem_be_o), 32'(e.be));
        check("mem_we",   32'(mem_if.mem_we_o), 32'(e.we));
        if (e.we) check("mem_wdata", mem_if.mem_wdata_o, e.wdata);
        check("ready_busy", 32'(ready_o), 32'd0);
        if (mem_if.mem_gnt_i) void'(mreq_q.pop_front());
      end
    end
    if (done_o === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("done_spurious", 32'(done_o), 32'd0);
      end else begin
        r = resp_q.pop_front();
        check("err", 32'(err_o), 32'(r.err));
        if (r.chk_rdata) check("rdata", rdata_o, r.rdata);
        check("done_cycle", 32'(cyc), 32'(r.done_cyc));
        check("ready_in_resp", 32'(ready_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst                 = 1'b1;
    req_valid_i         = 1'b0;
    req_we_i            = 1'b0;
    req_funct3_i        = 3'd0;
    req_addr_i          = 32'd0;
    req_wdata_i         = 32'd0;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready",   32'(ready_o),          32'd1);
    check("reset_mem_req", 32'(mem_if.mem_req_o), 32'd0);
    check("reset_done",    32'(done_o),           32'd0);
    check("reset_err",     32'(err_o),            32'd0);
    check("reset_addr",    mem_if.mem_addr_o,     32'd0);
    check("reset_rdata",   rdata_o,               32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0); // LW
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1, 1'b0); // LB
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1, 1'b0); // LBU
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0); // SH, slow grant
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 1, 1'b0); // misaligned LW
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 1, 1'b0);         // illegal load
    issue(1'b1, 3'b100, 32'h0000_0040, 32'h55, 32'h0, 0, 0, 1'b0);        // illegal store
    issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 0, 1'b0); // LH, rvalid with gnt
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 0, -1, 1'b0);        // watchdog expiry
    // Stray read data while idle produces nothing.
    mem_if.mem_rvalid_i = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_rvalid_i = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 1, 1, 1'b1);         // reset in WAIT
    issue(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 0, 0, 1'b0); // SW after reset

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("mreq_queue_drained", 32'(mreq_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
